// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : RV32I opcode, format and funct constants shared by the encoder.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_U = 7'b0110111;
  localparam logic [6:0] OP_J = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [6:0] F7_ADD         = 7'b0000000;
  localparam logic [6:0] F7_SUB         = 7'b0100000;
  localparam logic [6:0] F7_MUL         = 7'b0000001;
  localparam logic [6:0] F7_SHIFT_LOGIC = 7'b0000000;
  localparam logic [6:0] F7_SHIFT_ARITH = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rv_field_pack.sv
`default_nettype none
// ============================================================================
// Module   : rv_field_pack
// Purpose  : Combinational RV32I field packer with legality check.
//            Macro RV_ENC_MUL_EN makes R-format funct7=0000001 legal.
// Revision : 1.0 - initial release
// ============================================================================
module rv_field_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [2:0]  f3,
  input  logic [6:0]  f7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

`ifdef RV_ENC_MUL_EN
  localparam logic c_MUL_EN = 1'b1;
`else
  localparam logic c_MUL_EN = 1'b0;
`endif

  fmt_e w_fmt;
  logic w_fits12;
  logic w_fitsB;
  logic w_fitsJ;

  assign w_fmt    = fmt_e'(fmt);
  // Range checks: every bit above the field's sign bit must match it.
  assign w_fits12 = (&imm[31:11]) || ~(|imm[31:11]);
  assign w_fitsB  = (&imm[31:12]) || ~(|imm[31:12]);
  assign w_fitsJ  = (&imm[31:20]) || ~(|imm[31:20]);

  always_comb begin
    word    = '0;
    illegal = 1'b1;
    case (w_fmt)
      FMT_R: begin
        word    = {f7, rs2, rs1, f3, rd, OP_R};
        illegal = !((f7 == F7_ADD)
                 || (f7 == F7_SUB && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA))
                 || (c_MUL_EN && f7 == F7_MUL));
      end
      FMT_I: begin
        word    = {imm[11:0], rs1, f3, rd, OP_I};
        illegal = !w_fits12
               || (f3 == F3_SLL && imm[11:5] != F7_SHIFT_LOGIC)
               || (f3 == F3_SRL_SRA && imm[11:5] != F7_SHIFT_LOGIC
                                    && imm[11:5] != F7_SHIFT_ARITH);
      end
      FMT_S: begin
        word    = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
        illegal = !w_fits12;
      end
      FMT_B: begin
        word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_B};
        illegal = !w_fitsB || imm[0];
      end
      FMT_U: begin
        word    = {imm[31:12], rd, OP_U};
        illegal = |imm[11:0];
      end
      FMT_J: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
        illegal = !w_fitsJ || imm[0];
      end
      default: begin
        word    = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rv_instr_encoder
// Purpose  : Session-based RV32I encoder streaming words into instruction
//            memory. Optional macro RV_ENC_MUL_EN enables M-extension R-format.
// Revision : 1.0 - initial release
// ============================================================================
module rv_instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [2:0]        in_f3,
  input  logic [6:0]        in_f7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_word,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_cnt
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_outAddr;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_outValid;
  logic [31:0]       r_outWord;
  logic              r_done;
  logic              r_err;
  logic [7:0]        r_errCnt;

  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_inFire;
  logic              w_nextValid;
  logic [CNT_W-1:0]  w_nextRem;

  rv_field_pack u_pack (
    .fmt     (in_fmt),
    .f3      (in_f3),
    .f7      (in_f7),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (w_word),
    .illegal (w_illegal)
  );

  assign in_ready    = (r_state == ST_LOAD) && (r_remaining != '0)
                    && (!r_outValid || out_ready);
  assign w_inFire    = in_valid && in_ready;
  assign w_nextValid = (w_inFire && !w_illegal) || (r_outValid && !out_ready);
  assign w_nextRem   = r_remaining - CNT_W'(w_inFire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_outAddr   <= '0;
      r_remaining <= '0;
      r_outValid  <= 1'b0;
      r_outWord   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_errCnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_remaining <= count;
            r_err       <= 1'b0;
            r_errCnt    <= '0;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_outValid  <= w_nextValid;
          r_remaining <= w_nextRem;
          if (w_inFire) begin
            if (w_illegal) begin
              r_err <= 1'b1;
              if (r_errCnt != 8'hFF) r_errCnt <= r_errCnt + 8'd1;
            end else begin
              r_outWord <= w_word;
              r_outAddr <= r_addr;
              r_addr    <= r_addr + ADDR_W'(1);
            end
          end
          // Look ahead so done lands one cycle after the last handshake.
          if (w_nextRem == '0 && !w_nextValid) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_outValid;
  assign out_addr  = r_outAddr;
  assign out_word  = r_outWord;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign err_cnt   = r_errCnt;

endmodule
`default_nettype wire

// File: tb/tb_rv_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_instr_encoder
// Purpose  : Self-checking bench for rv_instr_encoder against a field-rule model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rv_instr_encoder;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 11;
`ifdef RV_ENC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  count = '0;
  logic in_valid = 1'b0, in_ready;
  logic [2:0] in_fmt = '0, in_f3 = '0;
  logic [6:0] in_f7 = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic out_valid, out_ready = 1'b0;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0] out_word;
  logic busy, done, err;
  logic [7:0] err_cnt;

  rv_instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_f3(in_f3),
    .in_f7(in_f7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_word(out_word), .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int rdyMode = 0;  // 0: ready high, 1: random, 2: driven by the test
  int doneCount = 0, doneCyc = 0, doneBase = 0, stabErr = 0;
  int startCyc = 0, accCyc = 0, mAddr = 0, mErr = 0;
  logic [ADDR_W-1:0] expAddr[$], gotAddr[$];
  logic [31:0] expWord[$], gotWord[$];
  int gotCyc[$];
  logic pV = 1'b0, pR = 1'b0;
  logic [ADDR_W-1:0] pA = '0;
  logic [31:0] pW = '0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    if (rdyMode == 0) out_ready = 1'b1;
    else if (rdyMode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Write monitor: records handshakes, done pulses and output-hold violations.
  always @(negedge clk) begin
    if (!rst_n) begin
      pV <= 1'b0;
    end else begin
      if (pV && !pR && (out_valid !== 1'b1 || out_addr !== pA || out_word !== pW))
        stabErr <= stabErr + 1;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        gotAddr.push_back(out_addr);
        gotWord.push_back(out_word);
        gotCyc.push_back(cyc);
      end
      if (done === 1'b1) begin
        doneCount <= doneCount + 1;
        doneCyc   <= cyc;
      end
      pV <= out_valid; pR <= out_ready; pA <= out_addr; pW <= out_word;
    end
  end

  // Reference: RV32I field rules and bit placement from plain arithmetic.
  function automatic bit refEncode(input int fmt, input int f3, input int f7, input int rd,
                                   input int rs1, input int rs2, input int imm,
                                   output logic [31:0] w);
    logic [31:0] u, regs;
    bit ok;
    u = imm; w = '0; ok = 1'b0;
    regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
    case (fmt)
      0: begin
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)) || (MUL_EN && f7 == 1);
        w  = (32'(f7) << 25) | regs | (32'(rd) << 7) | 32'h33;
      end
      1: begin
        ok = (imm >= -2048) && (imm <= 2047);
        if (f3 == 1) ok = ok && (((u >> 5) & 127) == 0);
        if (f3 == 5) ok = ok && ((((u >> 5) & 127) == 0) || (((u >> 5) & 127) == 32));
        w  = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h13;
      end
      2: begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = (((u >> 5) & 127) << 25) | regs | ((u & 31) << 7) | 32'h23;
      end
      3: begin
        ok = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
        w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | regs
           | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      end
      4: begin
        ok = ((u & 32'hFFF) == 0);
        w  = (u & 32'hFFFFF000) | (32'(rd) << 7) | 32'h37;
      end
      5: begin
        ok = (imm >= -(1 << 20)) && (imm <= (1 << 20) - 2) && (imm % 2 == 0);
        w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
           | (((u >> 12) & 255) << 12) | (32'(rd) << 7) | 32'h6F;
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  task automatic start_session(input int base, input int cnt);
    expAddr.delete(); expWord.delete();
    gotAddr.delete(); gotWord.delete(); gotCyc.delete();
    mAddr = base; mErr = 0; doneBase = doneCount;
    start = 1'b1; base_addr = base[ADDR_W-1:0]; count = cnt[CNT_W-1:0]; startCyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int fmt, input int f3, input int f7, input int rd,
                      input int rs1, input int rs2, input int imm);
    logic [31:0] w;
    bit legal, ok;
    int g;
    in_valid = 1'b1; in_fmt = fmt[2:0]; in_f3 = f3[2:0]; in_f7 = f7[6:0];
    in_rd = rd[4:0]; in_rs1 = rs1[4:0]; in_rs2 = rs2[4:0]; in_imm = imm;
    ok = 1'b0; g = 0;
    while (!ok && g < 500) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      if (ok) accCyc = cyc;
      @(posedge clk); #1;
      g++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout in_ready never seen, fmt=%0d", fmt);
    end else begin
      legal = refEncode(fmt, f3, f7, rd, rs1, rs2, imm, w);
      if (legal) begin
        expAddr.push_back(mAddr[ADDR_W-1:0]); expWord.push_back(w);
        mAddr = (mAddr + 1) % (1 << ADDR_W);
      end else mErr++;
    end
  endtask

  task automatic wait_done(output bit ok);
    int g = 0;
    while (doneCount == doneBase && g < 3000) begin @(posedge clk); #1; g++; end
    ok = (doneCount != doneBase);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl got in_ready=%b out_valid=%b busy=%b done=%b exp 0", in_ready, out_valid, busy, done); end
    tests++; if (out_addr !== '0 || out_word !== '0) begin
      fails++; $display("FAIL reset_data got addr=%h word=%h exp 0", out_addr, out_word); end
    tests++; if (err !== 1'b0 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_err got err=%b err_cnt=%0d exp 0", err, err_cnt); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    bit ok;
    rdyMode = 0;
    start_session(16, 1);
    send(0, 0, 0, 3, 1, 2, 0);
    wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL add_done got none exp pulse"); end
    tests++; if (gotWord.size() != 1 || gotWord[0] !== 32'h002081B3 || gotAddr[0] !== 10'h010) begin
      fails++; $display("FAIL add_write got n=%0d word=%h addr=%h exp 002081b3@010", gotWord.size(), gotWord[0], gotAddr[0]); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL add_err got %b exp 0", err); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int acc0;
    rdyMode = 0;
    start_session(32, 2);
    send(0, 0, 32, 5, 6, 7, 0);
    acc0 = accCyc;
    send(1, 0, 0, 1, 0, 0, -1);
    wait_done(ok);
    tests++; if (!ok || gotWord.size() != 2 || gotWord[0] !== 32'h407302B3 || gotWord[1] !== 32'hFFF00093) begin
      fails++; $display("FAIL b2b_words got n=%0d %h %h exp 407302b3 fff00093", gotWord.size(), gotWord[0], gotWord[1]); end
    tests++; if (gotAddr[0] !== 10'h020 || gotAddr[1] !== 10'h021) begin
      fails++; $display("FAIL b2b_addr got %h %h exp 020 021", gotAddr[0], gotAddr[1]); end
    tests++; if (gotCyc[0] != acc0 + 1 || gotCyc[1] != gotCyc[0] + 1) begin
      fails++; $display("FAIL b2b_timing got acc=%0d w0=%0d w1=%0d exp w0=acc+1 w1=w0+1", acc0, gotCyc[0], gotCyc[1]); end
  endtask

  task automatic test_beq_lui();
    bit ok;
    rdyMode = 0;
    start_session(48, 2);
    send(3, 0, 0, 0, 1, 2, 8);
    send(4, 0, 0, 10, 0, 0, 32'h12345000);
    wait_done(ok);
    tests++; if (!ok || gotWord.size() != 2 || gotWord[0] !== 32'h00208463 || gotWord[1] !== 32'h12345537) begin
      fails++; $display("FAIL beq_lui got n=%0d %h %h exp 00208463 12345537", gotWord.size(), gotWord[0], gotWord[1]); end
  endtask

  task automatic test_illegal_mid();
    bit ok;
    rdyMode = 0;
    start_session(64, 3);
    send(0, 0, 0, 3, 1, 2, 0);
    send(1, 0, 0, 1, 0, 0, 2048);
    send(0, 0, 0, 4, 1, 2, 0);
    wait_done(ok);
    tests++; if (!ok || gotAddr.size() != 2 || gotAddr[0] !== 10'h040 || gotAddr[1] !== 10'h041) begin
      fails++; $display("FAIL illegal_mid_addr got n=%0d %h %h exp 2 writes 040 041", gotAddr.size(), gotAddr[0], gotAddr[1]); end
    tests++; if (err !== 1'b1 || err_cnt !== 8'd1) begin
      fails++; $display("FAIL illegal_mid_err got err=%b cnt=%0d exp 1 1", err, err_cnt); end
  endtask

  task automatic test_mul();
    bit ok;
    rdyMode = 0;
    start_session(80, 1);
    send(0, 0, 1, 3, 1, 2, 0);
    wait_done(ok);
`ifdef RV_ENC_MUL_EN
    tests++; if (!ok || gotWord.size() != 1 || gotWord[0] !== 32'h022081B3 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL mul got n=%0d word=%h cnt=%0d exp 022081b3 cnt 0", gotWord.size(), gotWord[0], err_cnt); end
`else
    tests++; if (!ok || gotWord.size() != 0 || err_cnt !== 8'd1) begin
      fails++; $display("FAIL mul got n=%0d cnt=%0d exp no write cnt 1", gotWord.size(), err_cnt); end
`endif
  endtask

  task automatic test_count_zero();
    bit ok;
    start_session(5, 0);
    wait_done(ok);
    tests++; if (!ok || doneCyc != startCyc + 2 || gotWord.size() != 0) begin
      fails++; $display("FAIL count_zero got done_at=%0d writes=%0d exp done_at=%0d writes=0", doneCyc - startCyc, gotWord.size(), 2); end
  endtask

  task automatic test_wrap();
    bit ok;
    rdyMode = 0;
    start_session(10'h3FF, 2);
    send(0, 0, 0, 1, 2, 3, 0);
    send(1, 0, 0, 4, 5, 0, 100);
    wait_done(ok);
    tests++; if (!ok || gotAddr.size() != 2 || gotAddr[0] !== 10'h3FF || gotAddr[1] !== 10'h000) begin
      fails++; $display("FAIL wrap got n=%0d %h %h exp 3ff 000", gotAddr.size(), gotAddr[0], gotAddr[1]); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] w0;
    int s0;
    rdyMode = 2; out_ready = 1'b0;
    s0 = stabErr;
    start_session(256, 3);
    send(0, 0, 0, 1, 2, 3, 0);
    w0 = expWord[0];
    start = 1'b1; base_addr = 10'h200; count = 11'd5;  // must be ignored mid-session
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || out_addr !== 10'h100 || out_word !== w0) begin
        fails++; $display("FAIL bp_hold cyc%0d got v=%b a=%h w=%h exp 1 100 %h", i, out_valid, out_addr, out_word, w0); end
      tests++; if (in_ready !== 1'b0) begin
        fails++; $display("FAIL bp_in_ready cyc%0d got %b exp 0", i, in_ready); end
      @(posedge clk); #1; start = 1'b0;
    end
    rdyMode = 0; out_ready = 1'b1;
    send(2, 2, 0, 0, 4, 5, -20);
    send(5, 0, 0, 1, 0, 0, 2048);
    wait_done(ok);
    tests++; if (!ok || gotAddr.size() != 3) begin
      fails++; $display("FAIL bp_count got n=%0d exp 3", gotAddr.size()); end
    for (int i = 0; i < 3 && i < gotAddr.size(); i++) begin
      tests++; if (gotAddr[i] !== expAddr[i] || gotWord[i] !== expWord[i]) begin
        fails++; $display("FAIL bp_write%0d got %h@%h exp %h@%h", i, gotWord[i], gotAddr[i], expWord[i], expAddr[i]); end
    end
    tests++; if (stabErr != s0) begin fails++; $display("FAIL bp_stable got %0d violations exp 0", stabErr - s0); end
  endtask

  task automatic test_saturate();
    bit ok;
    rdyMode = 0;
    start_session(0, 300);
    for (int i = 0; i < 300; i++) send(6 + (i % 2), i % 8, i % 128, 1, 2, 3, i);
    wait_done(ok);
    tests++; if (!ok || err !== 1'b1 || err_cnt !== 8'd255 || gotWord.size() != 0) begin
      fails++; $display("FAIL saturate got err=%b cnt=%0d writes=%0d exp 1 255 0", err, err_cnt, gotWord.size()); end
  endtask

  task automatic test_random();
    bit ok;
    int n, imm, k, f7, s0;
    int bnd[12] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                    1048574, 1048576, -1048576, -1048578};
    s0 = stabErr;
    rdyMode = 1;
    for (int s = 0; s < 6; s++) begin
      n = $urandom_range(1, 20);
      start_session($urandom_range(0, 1023), n);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 4);
        case (k)
          0: imm = int'($urandom_range(0, 8191)) - 4096;
          1: imm = bnd[$urandom_range(0, 11)];
          2: imm = int'($urandom);
          3: imm = int'($urandom & 32'hFFFFF000);
          default: imm = int'($urandom_range(0, 1)) * 1024 + int'($urandom_range(0, 31));
        endcase
        case ($urandom_range(0, 3))
          0: f7 = 0;
          1: f7 = 32;
          2: f7 = 1;
          default: f7 = $urandom_range(0, 127);
        endcase
        send($urandom_range(0, 7), $urandom_range(0, 7), f7, $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), imm);
      end
      wait_done(ok);
      tests++; if (!ok || gotWord.size() != expWord.size()) begin
        fails++; $display("FAIL rand%0d_count got %0d writes exp %0d", s, gotWord.size(), expWord.size()); end
      for (int i = 0; i < expWord.size() && i < gotWord.size(); i++) begin
        tests++; if (gotWord[i] !== expWord[i] || gotAddr[i] !== expAddr[i]) begin
          fails++; $display("FAIL rand%0d_w%0d got %h@%h exp %h@%h", s, i, gotWord[i], gotAddr[i], expWord[i], expAddr[i]); end
      end
      tests++; if (err_cnt !== 8'(mErr) || err !== (mErr > 0)) begin
        fails++; $display("FAIL rand%0d_err got err=%b cnt=%0d exp %b %0d", s, err, err_cnt, mErr > 0, mErr); end
    end
    tests++; if (stabErr != s0) begin fails++; $display("FAIL rand_stable got %0d violations exp 0", stabErr - s0); end
  endtask

  task automatic test_reset_mid();
    rdyMode = 2; out_ready = 1'b0;
    start_session(16, 4);
    send(0, 0, 0, 3, 1, 2, 0);
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0
              || out_addr !== '0 || out_word !== '0 || err !== 1'b0 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_mid got rdy=%b v=%b busy=%b done=%b a=%h w=%h err=%b cnt=%0d exp all 0",
                        in_ready, out_valid, busy, done, out_addr, out_word, err, err_cnt); end
    @(posedge clk); #1; rst_n = 1'b1;
    rdyMode = 0; out_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    tests++; if (doneCount != doneBase || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_mid_after got done_pulses=%0d busy=%b v=%b exp 0 0 0", doneCount - doneBase, busy, out_valid); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_beq_lui();
    test_illegal_mid();
    test_mul();
    test_count_zero();
    test_wrap();
    test_backpressure();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
